mat_index_counter: RTL

- Parametrised successor of the single enable-driven up-counter: a two-level nested index generator (row, col) that walks a rows x cols tile of the dense operand for the sparse-dense multiply datapath.
- Started by a one-cycle start pulse; presents indices with a valid/ready handshake.
- Reports last-in-row and last-in-tile flags and a running beat count, then pulses done.
- Sits between the tile controller and the operand address generators.

---
 rtl/mat_index_counter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mat_index_counter.sv
// -----------------------------------------------------------------------------
// mat_index_counter
//
// Two-level nested (row, col) index generator that walks a rows x cols tile of
// the dense operand for the sparse-dense multiply datapath. A one-cycle start
// pulse captures the inclusive limits and launches the walk. Indices are then
// presented under a valid/ready handshake. When the final index has been
// accepted, the block pulses done for one cycle and returns to idle.
//
// Parameters
//   ROW_W      width of row index / row_limit
//   COL_W      width of col index / col_limit
//   ROW_MAJOR  1: col is the inner (fast) index, 0: row is the inner index
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   start       begin a tile walk (only honoured while idle)
//   row_limit   last row index, inclusive, captured on accepted start
//   col_limit   last col index, inclusive, captured on accepted start
//   ready       downstream accepts the current index this cycle
//   row, col    current index
//   valid       row/col carry a live index
//   inner_last  current index is the last one of the inner loop
//   tile_last   current index is the final one of the tile
//   beat_cnt    handshakes completed in the current or most recent tile
//   busy        walk in progress (RUN or DONE)
//   done        one-cycle pulse after the final handshake
// -----------------------------------------------------------------------------
module mat_index_counter #(
  parameter int ROW_W     = 10,
  parameter int COL_W     = 10,
  parameter int ROW_MAJOR = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROW_W-1:0]       row_limit,
  input  logic [COL_W-1:0]       col_limit,
  input  logic                   ready,
  output logic [ROW_W-1:0]       row,
  output logic [COL_W-1:0]       col,
  output logic                   valid,
  output logic                   inner_last,
  output logic                   tile_last,
  output logic [ROW_W+COL_W-1:0] beat_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam int BEAT_W = ROW_W + COL_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_lim_q, row_lim_d;
  logic [COL_W-1:0]    col_lim_q, col_lim_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;

  logic row_at_lim;
  logic col_at_lim;
  logic inner_at_lim;
  logic outer_at_lim;
  logic handshake;

  assign row_at_lim = (row_q == row_lim_q);
  assign col_at_lim = (col_q == col_lim_q);

  // Loop order only changes which comparator plays the inner role.
  assign inner_at_lim = (ROW_MAJOR != 0) ? col_at_lim : row_at_lim;
  assign outer_at_lim = (ROW_MAJOR != 0) ? row_at_lim : col_at_lim;

  assign valid      = (state_q == S_RUN);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign inner_last = valid & inner_at_lim;
  assign tile_last  = inner_last & outer_at_lim;
  assign handshake  = valid & ready;

  assign row      = row_q;
  assign col      = col_q;
  assign beat_cnt = beat_q;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    row_lim_d = row_lim_q;
    col_lim_d = col_lim_q;
    beat_d    = beat_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          row_lim_d = row_limit;
          col_lim_d = col_limit;
          row_d     = '0;
          col_d     = '0;
          beat_d    = '0;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (handshake) begin
          // A full 2^ROW_W x 2^COL_W tile wraps the count to 0; termination
          // relies on tile_last, not on the count.
          beat_d = beat_q + 1'b1;
          if (tile_last) begin
            // Final indices stay visible on row/col after the walk.
            state_d = S_DONE;
          end else if (ROW_MAJOR != 0) begin
            if (col_at_lim) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else begin
            if (row_at_lim) begin
              row_d = '0;
              col_d = col_q + 1'b1;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end

      S_DONE: begin
        // start is deliberately not looked at here.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of all others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      row_lim_q <= '0;
      col_lim_q <= '0;
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      row_lim_q <= row_lim_d;
      col_lim_q <= col_lim_d;
      beat_q    <= beat_d;
    end
  end

endmodule
